bus_arbiter: RTL and testbench

Two-master arbiter placed between the CPU core and the address decoder/data mux. It shares the single 16-bit peripheral bus between the CPU (master 0) and a DMA/loader master (master 1). It sequences ownership with a 3-state FSM, stalls the CPU through its enable input while the DMA master owns the bus, and bounds DMA bursts so the CPU keeps making progress. It also holds read data stable for the CPU across stalls and returns DMA read data one cycle after the address is accepted.

---
 rtl/bus_arbiter.sv | 161 ++++++++++++++++
 tb/tb_bus_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master arbiter sharing the 16-bit peripheral bus between
// the CPU (master 0) and a DMA/loader master (master 1).
// Optional feature macro: BUS_ARB_FAIRNESS_EN. When defined, DMA grants are
// bounded to MAX_BURST accesses and an S_GAP state forces one CPU access
// before the DMA master may own the bus again. When undefined, DMA keeps the
// bus until it drops dma_req.
module bus_arbiter #(
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned BURST_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    // CPU side
    input  logic [15:0] cpu_next_addr,
    input  logic        cpu_next_rd,
    input  logic        cpu_next_we,
    input  logic [7:0]  cpu_do,
    output logic        cpu_enable,
    output logic [7:0]  cpu_di,
    // DMA side
    input  logic        dma_req,
    input  logic [15:0] dma_addr,
    input  logic        dma_we,
    input  logic [7:0]  dma_wdata,
    output logic        dma_ack,
    output logic [7:0]  dma_rdata,
    output logic        dma_rvalid,
    // Decoder side
    output logic [15:0] bus_next_addr,
    output logic        bus_next_rd,
    output logic        bus_next_we,
    output logic [7:0]  bus_do,
    input  logic        bus_enable,
    input  logic [7:0]  bus_di
);

    typedef enum logic [1:0] {
        S_CPU = 2'd0,
        S_DMA = 2'd1,
        S_GAP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_dma_owner;
    logic        r_cpu_acc_q;
    logic [7:0]  r_cpu_hold;
    logic        r_dma_rvalid;

`ifdef BUS_ARB_FAIRNESS_EN
    localparam logic [BURST_W-1:0] LP_BURST_LAST = BURST_W'(MAX_BURST - 1);

    logic [BURST_W-1:0] r_burst_cnt;
    logic               w_burst_last;

    assign w_burst_last = (r_burst_cnt == LP_BURST_LAST);
`else
    // Burst parameters only matter when the fairness limit is built in.
    logic w_unused_cfg;
    assign w_unused_cfg = (MAX_BURST < (32'd1 << BURST_W));
`endif

    assign w_dma_owner = (r_state == S_DMA);

    // State register; reset returns ownership to the CPU immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_CPU;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and the combinational bus/handshake mux.
    always_comb begin
        w_state_nxt   = r_state;
        bus_next_addr = cpu_next_addr;
        bus_next_rd   = cpu_next_rd;
        bus_next_we   = cpu_next_we;
        bus_do        = cpu_do;
        cpu_enable    = bus_enable;
        dma_ack       = 1'b0;

        if (w_dma_owner) begin
            bus_next_addr = dma_addr;
            bus_next_rd   = dma_req & ~dma_we;
            bus_next_we   = dma_req & dma_we;
            bus_do        = dma_wdata;
            cpu_enable    = 1'b0;
            dma_ack       = dma_req & bus_enable;
        end

        case (r_state)
            S_CPU: begin
                // The CPU access presented this cycle completes before the switch.
                if (dma_req && bus_enable) begin
                    w_state_nxt = S_DMA;
                end
            end
            S_DMA: begin
                if (!dma_req) begin
                    w_state_nxt = S_CPU;
                end
`ifdef BUS_ARB_FAIRNESS_EN
                else if (bus_enable && w_burst_last) begin
                    w_state_nxt = S_GAP;
                end
`endif
            end
            S_GAP: begin
                if (bus_enable) begin
                    w_state_nxt = S_CPU;
                end
            end
            default: begin
                w_state_nxt = S_CPU;
            end
        endcase
    end

`ifdef BUS_ARB_FAIRNESS_EN
    // Counts DMA acks within the current grant; cleared on each new grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_burst_cnt <= '0;
        end else if ((r_state == S_CPU) && (w_state_nxt == S_DMA)) begin
            r_burst_cnt <= '0;
        end else if (dma_ack) begin
            r_burst_cnt <= r_burst_cnt + 1'b1;
        end
    end
`endif

    // Track whether the CPU's read data arrives this cycle, and keep a copy
    // so the CPU sees a stable value while it is stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cpu_acc_q <= 1'b0;
            r_cpu_hold  <= '0;
        end else begin
            r_cpu_acc_q <= cpu_enable & (cpu_next_rd | cpu_next_we | ~w_dma_owner);
            if (r_cpu_acc_q) begin
                r_cpu_hold <= bus_di;
            end
        end
    end

    // DMA read data is valid the cycle after its address was accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dma_rvalid <= 1'b0;
        end else begin
            r_dma_rvalid <= dma_ack & ~dma_we;
        end
    end

    assign cpu_di     = r_cpu_acc_q ? bus_di : r_cpu_hold;
    assign dma_rdata  = bus_di;
    assign dma_rvalid = r_dma_rvalid;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter. Inputs are driven 1 time unit
// after each rising edge; outputs are sampled 1 time unit later.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_next_addr;
    logic        cpu_next_rd;
    logic        cpu_next_we;
    logic [7:0]  cpu_do;
    logic        cpu_enable;
    logic [7:0]  cpu_di;
    logic        dma_req;
    logic [15:0] dma_addr;
    logic        dma_we;
    logic [7:0]  dma_wdata;
    logic        dma_ack;
    logic [7:0]  dma_rdata;
    logic        dma_rvalid;
    logic [15:0] bus_next_addr;
    logic        bus_next_rd;
    logic        bus_next_we;
    logic [7:0]  bus_do;
    logic        bus_enable;
    logic [7:0]  bus_di = 8'h00;

    int total = 0;
    int bad   = 0;

    bus_arbiter #(.MAX_BURST(4), .BURST_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_next_addr(cpu_next_addr),
        .cpu_next_rd  (cpu_next_rd),
        .cpu_next_we  (cpu_next_we),
        .cpu_do       (cpu_do),
        .cpu_enable   (cpu_enable),
        .cpu_di       (cpu_di),
        .dma_req      (dma_req),
        .dma_addr     (dma_addr),
        .dma_we       (dma_we),
        .dma_wdata    (dma_wdata),
        .dma_ack      (dma_ack),
        .dma_rdata    (dma_rdata),
        .dma_rvalid   (dma_rvalid),
        .bus_next_addr(bus_next_addr),
        .bus_next_rd  (bus_next_rd),
        .bus_next_we  (bus_next_we),
        .bus_do       (bus_do),
        .bus_enable   (bus_enable),
        .bus_di       (bus_di)
    );

    always #5 clk = ~clk;

    // RAM behind the decoder: read data = low address byte + 0x10, one cycle late.
    always @(posedge clk) begin
        if (bus_enable && bus_next_rd) begin
            bus_di <= bus_next_addr[7:0] + 8'h10;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; bus_enable = 1'b1;
        cpu_next_rd = 1'b1; cpu_next_we = 1'b0; cpu_next_addr = 16'h1234; cpu_do = 8'h5A;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0200; dma_wdata = 8'h00;
        #1;
        total++; if (cpu_di !== 8'h00) begin bad++; $display("FAIL rst_cpu_di got=%h want=00", cpu_di); end
        total++; if (dma_ack !== 1'b0) begin bad++; $display("FAIL rst_dma_ack got=%b want=0", dma_ack); end
        total++; if (cpu_enable !== 1'b1) begin bad++; $display("FAIL rst_cpu_en got=%b want=1", cpu_enable); end
        total++; if (bus_next_addr !== 16'h1234) begin bad++; $display("FAIL rst_bus_addr got=%h want=1234", bus_next_addr); end
        total++; if (bus_next_rd !== 1'b1) begin bad++; $display("FAIL rst_bus_rd got=%b want=1", bus_next_rd); end
        total++; if (bus_do !== 8'h5A) begin bad++; $display("FAIL rst_bus_do got=%h want=5a", bus_do); end
        total++; if (dma_rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%b want=0", dma_rvalid); end
        bus_enable = 1'b0;
        #1;
        total++; if (cpu_enable !== 1'b0) begin bad++; $display("FAIL rst_cpu_en_follow got=%b want=0", cpu_enable); end
        tick; tick;
        total++; if (cpu_di !== 8'h00) begin bad++; $display("FAIL rst_cpu_di_held got=%h want=00", cpu_di); end
        reset = 1'b0; dma_req = 1'b0; cpu_next_rd = 1'b0; bus_enable = 1'b1;
        #1;
    endtask

    task automatic test_cpu_reads;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (i < 4) begin
                cpu_next_rd = 1'b1; cpu_next_addr = 16'(i);
            end else begin
                cpu_next_rd = 1'b0;
            end
            #1;
            total++; if (cpu_enable !== 1'b1) begin bad++; $display("FAIL cpu_rd_en[%0d] got=%b want=1", i, cpu_enable); end
            total++; if (dma_ack !== 1'b0) begin bad++; $display("FAIL cpu_rd_ack[%0d] got=%b want=0", i, dma_ack); end
            if (i < 4) begin
                total++; if (bus_next_addr !== 16'(i)) begin bad++; $display("FAIL cpu_rd_addr[%0d] got=%h want=%h", i, bus_next_addr, 16'(i)); end
            end
            if (i > 0) begin
                total++; if (cpu_di !== 8'(8'h10 + i - 1)) begin bad++; $display("FAIL cpu_rd_di[%0d] got=%h want=%h", i, cpu_di, 8'(8'h10 + i - 1)); end
            end
        end
    endtask

    task automatic test_dma_read;
        // A: CPU read 0x0100 in flight while DMA requests a read of 0x0200.
        tick;
        cpu_next_rd = 1'b1; cpu_next_addr = 16'h0100;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0200;
        #1;
        total++; if (bus_next_addr !== 16'h0100) begin bad++; $display("FAIL dr_a_addr got=%h want=0100", bus_next_addr); end
        total++; if (cpu_enable !== 1'b1) begin bad++; $display("FAIL dr_a_en got=%b want=1", cpu_enable); end
        total++; if (dma_ack !== 1'b0) begin bad++; $display("FAIL dr_a_ack got=%b want=0", dma_ack); end
        // B: DMA owns the bus, CPU waits with its next address.
        tick;
        cpu_next_addr = 16'h0101;
        #1;
        total++; if (bus_next_addr !== 16'h0200) begin bad++; $display("FAIL dr_b_addr got=%h want=0200", bus_next_addr); end
        total++; if (bus_next_rd !== 1'b1 || bus_next_we !== 1'b0) begin bad++; $display("FAIL dr_b_rdwe got=%b%b want=10", bus_next_rd, bus_next_we); end
        total++; if (cpu_enable !== 1'b0) begin bad++; $display("FAIL dr_b_en got=%b want=0", cpu_enable); end
        total++; if (dma_ack !== 1'b1) begin bad++; $display("FAIL dr_b_ack got=%b want=1", dma_ack); end
        total++; if (cpu_di !== 8'h10) begin bad++; $display("FAIL dr_b_cpu_di got=%h want=10", cpu_di); end
        // C: first read data returns, second DMA read to 0x0205.
        tick;
        dma_addr = 16'h0205;
        #1;
        total++; if (dma_rvalid !== 1'b1) begin bad++; $display("FAIL dr_c_rvalid got=%b want=1", dma_rvalid); end
        total++; if (dma_rdata !== 8'h10) begin bad++; $display("FAIL dr_c_rdata got=%h want=10", dma_rdata); end
        total++; if (dma_ack !== 1'b1) begin bad++; $display("FAIL dr_c_ack got=%b want=1", dma_ack); end
        total++; if (cpu_di !== 8'h10) begin bad++; $display("FAIL dr_c_cpu_di got=%h want=10", cpu_di); end
        // D: DMA releases; CPU read data must stay put although bus_di moved.
        tick;
        dma_req = 1'b0;
        #1;
        total++; if (dma_rvalid !== 1'b1) begin bad++; $display("FAIL dr_d_rvalid got=%b want=1", dma_rvalid); end
        total++; if (dma_rdata !== 8'h15) begin bad++; $display("FAIL dr_d_rdata got=%h want=15", dma_rdata); end
        total++; if (cpu_di !== 8'h10) begin bad++; $display("FAIL dr_d_cpu_di got=%h want=10", cpu_di); end
        total++; if (cpu_enable !== 1'b0) begin bad++; $display("FAIL dr_d_en got=%b want=0", cpu_enable); end
        total++; if (bus_next_rd !== 1'b0) begin bad++; $display("FAIL dr_d_bus_rd got=%b want=0", bus_next_rd); end
        // E: CPU owns the bus again.
        tick;
        #1;
        total++; if (cpu_enable !== 1'b1) begin bad++; $display("FAIL dr_e_en got=%b want=1", cpu_enable); end
        total++; if (bus_next_addr !== 16'h0101) begin bad++; $display("FAIL dr_e_addr got=%h want=0101", bus_next_addr); end
        total++; if (dma_rvalid !== 1'b0) begin bad++; $display("FAIL dr_e_rvalid got=%b want=0", dma_rvalid); end
        total++; if (cpu_di !== 8'h10) begin bad++; $display("FAIL dr_e_cpu_di got=%h want=10", cpu_di); end
        // F: CPU read of 0x0101 returns.
        tick;
        cpu_next_rd = 1'b0;
        #1;
        total++; if (cpu_di !== 8'h11) begin bad++; $display("FAIL dr_f_cpu_di got=%h want=11", cpu_di); end
    endtask

    task automatic test_wait_states;
        tick;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'hD100; dma_wdata = 8'hA5; bus_enable = 1'b1;
        #1;
        total++; if (cpu_enable !== 1'b1 || dma_ack !== 1'b0) begin bad++; $display("FAIL ws_switch en/ack got=%b%b want=10", cpu_enable, dma_ack); end
        for (int k = 0; k < 4; k++) begin
            tick;
            bus_enable = (k == 3);
            #1;
            total++; if (bus_next_addr !== 16'hD100 || bus_do !== 8'hA5) begin bad++; $display("FAIL ws_bus[%0d] got=%h/%h want=d100/a5", k, bus_next_addr, bus_do); end
            total++; if (bus_next_we !== 1'b1 || bus_next_rd !== 1'b0) begin bad++; $display("FAIL ws_rdwe[%0d] got=%b%b want=01", k, bus_next_rd, bus_next_we); end
            total++; if (cpu_enable !== 1'b0) begin bad++; $display("FAIL ws_en[%0d] got=%b want=0", k, cpu_enable); end
            total++; if (dma_ack !== (k == 3)) begin bad++; $display("FAIL ws_ack[%0d] got=%b want=%b", k, dma_ack, (k == 3)); end
        end
        tick;
        dma_req = 1'b0;
        #1;
        total++; if (dma_rvalid !== 1'b0) begin bad++; $display("FAIL ws_rvalid got=%b want=0", dma_rvalid); end
        total++; if (cpu_enable !== 1'b0 || dma_ack !== 1'b0) begin bad++; $display("FAIL ws_idle en/ack got=%b%b want=00", cpu_enable, dma_ack); end
`ifdef BUS_ARB_FAIRNESS_EN
        total++; if (dut.r_burst_cnt !== 8'd1) begin bad++; $display("FAIL ws_burst_cnt got=%0d want=1", dut.r_burst_cnt); end
`endif
        tick;
        #1;
        total++; if (cpu_enable !== 1'b1) begin bad++; $display("FAIL ws_return_en got=%b want=1", cpu_enable); end
    endtask

    task automatic test_reset_mid_dma;
        tick;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0230;
        cpu_next_rd = 1'b1; cpu_next_addr = 16'h0007;
        #1;
        tick;
        #1;
        total++; if (dma_ack !== 1'b1 || bus_next_addr !== 16'h0230) begin bad++; $display("FAIL rm_ack got=%b/%h want=1/0230", dma_ack, bus_next_addr); end
        reset = 1'b1;
        #1;
        total++; if (dma_ack !== 1'b0) begin bad++; $display("FAIL rm_ack_in_rst got=%b want=0", dma_ack); end
        total++; if (cpu_enable !== 1'b1) begin bad++; $display("FAIL rm_en_in_rst got=%b want=1", cpu_enable); end
        total++; if (cpu_di !== 8'h00) begin bad++; $display("FAIL rm_cpu_di got=%h want=00", cpu_di); end
        total++; if (bus_next_addr !== 16'h0007) begin bad++; $display("FAIL rm_bus_addr got=%h want=0007", bus_next_addr); end
        tick;
        total++; if (dma_rvalid !== 1'b0) begin bad++; $display("FAIL rm_rvalid got=%b want=0", dma_rvalid); end
        reset = 1'b0; dma_req = 1'b0;
        #1;
        total++; if (cpu_enable !== 1'b1 || bus_next_addr !== 16'h0007) begin bad++; $display("FAIL rm_resume got=%b/%h want=1/0007", cpu_enable, bus_next_addr); end
        tick;
        cpu_next_rd = 1'b0;
        #1;
        total++; if (cpu_di !== 8'h17) begin bad++; $display("FAIL rm_cpu_read got=%h want=17", cpu_di); end
    endtask

`ifdef BUS_ARB_FAIRNESS_EN
    // MAX_BURST = 4, ten DMA writes: 4 acks, gap, CPU slot, 4 acks, gap, CPU slot, 2 acks.
    task automatic test_back_to_back;
        logic exp_ack [17] = '{0,1,1,1,1,0,0,1,1,1,1,0,0,1,1,0,0};
        logic exp_en  [17] = '{1,0,0,0,0,1,1,0,0,0,0,1,1,0,0,0,1};
        int n = 0;
        dma_we = 1'b1;
        for (int c = 0; c < 17; c++) begin
            tick;
            dma_req = (n < 10); dma_addr = 16'hE000 + 16'(n); dma_wdata = 8'(8'h40 + n);
            #1;
            total++; if (dma_ack !== exp_ack[c]) begin bad++; $display("FAIL fair_ack[%0d] got=%b want=%b", c, dma_ack, exp_ack[c]); end
            total++; if (cpu_enable !== exp_en[c]) begin bad++; $display("FAIL fair_en[%0d] got=%b want=%b", c, cpu_enable, exp_en[c]); end
            if (dma_ack === 1'b1) begin
                total++; if (bus_do !== 8'(8'h40 + n)) begin bad++; $display("FAIL fair_do[%0d] got=%h want=%h", c, bus_do, 8'(8'h40 + n)); end
                n++;
            end
        end
        total++; if (n !== 10) begin bad++; $display("FAIL fair_ack_count got=%0d want=10", n); end
        dma_req = 1'b0;
    endtask
`else
    // No burst limit: 40 writes stall the CPU throughout.
    task automatic test_back_to_back;
        int n = 0;
        dma_we = 1'b1;
        for (int c = 0; c < 43; c++) begin
            tick;
            dma_req = (n < 40); dma_addr = 16'hE000 + 16'(n); dma_wdata = 8'(n);
            #1;
            total++; if (dma_ack !== (c >= 1 && c <= 40)) begin bad++; $display("FAIL b2b_ack[%0d] got=%b want=%b", c, dma_ack, (c >= 1 && c <= 40)); end
            total++; if (cpu_enable !== (c == 0 || c == 42)) begin bad++; $display("FAIL b2b_en[%0d] got=%b want=%b", c, cpu_enable, (c == 0 || c == 42)); end
            if (dma_ack === 1'b1) n++;
        end
        total++; if (n !== 40) begin bad++; $display("FAIL b2b_ack_count got=%0d want=40", n); end
        dma_req = 1'b0;
    endtask
`endif

    initial begin
        test_reset;
        test_cpu_reads;
        test_dma_read;
        test_wait_states;
        test_reset_mid_dma;
        test_back_to_back;
        tick;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
